// File: rtl/esp32_prog_pkg.sv
// esp32_prog_pkg: FSM state encoding and the nDTR/nRTS -> {EN,IO0} decode for esp32_prog_ctrl.
package esp32_prog_pkg;

    localparam logic [1:0] ST_POWERUP = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PROG    = 2'd2;

    // filtered {ndtr, nrts} codes
    localparam logic [1:0] PAIR_PROG = 2'b10;
    localparam logic [1:0] PAIR_IO0  = 2'b01;
    localparam logic [1:0] PAIR_BOTH = 2'b00;
    localparam logic [1:0] PAIR_IDLE = 2'b11;

    // decoded {EN, IO0} pairs
    localparam logic [1:0] EI_EN_LOW  = 2'b01;
    localparam logic [1:0] EI_IO0_LOW = 2'b10;
    localparam logic [1:0] EI_RUN     = 2'b11;

    function automatic logic [1:0] decode_pair(input logic [1:0] pair);
        return pair == PAIR_PROG ? EI_EN_LOW : pair == PAIR_IO0 ? EI_IO0_LOW : EI_RUN;
    endfunction

endpackage

// File: rtl/esp32_line_filter.sv
// esp32_line_filter: 2-FF synchroniser followed by a stability filter that accepts a new level
// only after it has been seen for C_filter_cycles consecutive cycles (0 = synchroniser only).
module esp32_line_filter #(
    parameter int   C_filter_cycles = 4,
    parameter logic C_init          = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= {2{C_init}};
        else        sync <= {sync[0], d};

    generate
        if (C_filter_cycles == 0) begin : g_bypass
            assign q = sync[1];
        end else begin : g_filter
            localparam int CW = $clog2(C_filter_cycles + 1);
            logic [CW-1:0] cnt;
            logic          filt;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    cnt  <= '0;
                    filt <= C_init;
                end else if (sync[1] == filt) begin
                    cnt <= '0;
                end else if (cnt == CW'(C_filter_cycles - 1)) begin
                    cnt  <= '0;
                    filt <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            assign q = filt;
        end
    endgenerate

endmodule

// File: rtl/esp32_prog_ctrl.sv
// esp32_prog_ctrl: FTDI nDTR/nRTS to ESP32 EN/bootstrap controller with power-up EN hold and release timeout.
// Optional ESP32_PROG_ACTIVITY_EN: each synced uart_act edge in PROG restarts the release timeout.
module esp32_prog_ctrl
    import esp32_prog_pkg::*;
#(
    parameter int                C_pins                 = 6,
    parameter logic [C_pins-1:0] C_follow_io0           = 6'b000011,
    parameter logic [C_pins-1:0] C_prog_value           = 6'b001100,
    parameter int                C_filter_cycles        = 4,
    parameter int                C_powerup_en_time      = 0,
    parameter int                C_prog_release_timeout = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ndtr,
    input  logic              nrts,
    input  logic              btn_disable,
    input  logic              uart_act,
    output logic              en_t,
    output logic [C_pins-1:0] boot_t,
    output logic [C_pins-1:0] boot_o,
    output logic              prog_active
);
    localparam int CW = (C_powerup_en_time > C_prog_release_timeout ?
                         C_powerup_en_time : C_prog_release_timeout) + 1;
    localparam logic [CW-1:0] POWERUP_LAST = CW'((64'd1 << C_powerup_en_time) - 64'd1);

    logic              ndtr_f, nrts_f, btn_s, act, trig, en_n, prog_n;
    logic [1:0]        pair, pair_q, ei, state, state_n;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc;
    logic [C_pins-1:0] boot_o_n;

    esp32_line_filter #(.C_filter_cycles(C_filter_cycles), .C_init(1'b1)) u_ndtr (
        .clk(clk), .rst_n(rst_n), .d(ndtr), .q(ndtr_f));
    esp32_line_filter #(.C_filter_cycles(C_filter_cycles), .C_init(1'b1)) u_nrts (
        .clk(clk), .rst_n(rst_n), .d(nrts), .q(nrts_f));
    esp32_line_filter #(.C_filter_cycles(0), .C_init(1'b0)) u_btn (
        .clk(clk), .rst_n(rst_n), .d(btn_disable), .q(btn_s));

`ifdef ESP32_PROG_ACTIVITY_EN
    logic act_s, act_q;
    esp32_line_filter #(.C_filter_cycles(0), .C_init(1'b0)) u_act (
        .clk(clk), .rst_n(rst_n), .d(uart_act), .q(act_s));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) act_q <= 1'b0;
        else        act_q <= act_s;
    assign act = act_s ^ act_q;
`else
    logic unused_uart_act;
    assign unused_uart_act = uart_act;
    assign act = 1'b0;
`endif

    assign pair    = {ndtr_f, nrts_f};
    assign ei      = decode_pair(pair);
    assign trig    = pair == PAIR_PROG && pair_q != PAIR_PROG;
    assign cnt_inc = cnt[C_prog_release_timeout] ? cnt : cnt + 1'b1;

    // Release is taken on the edge the counter reaches 2^n, so it lands exactly 2^n cycles after the trigger.
    always_comb begin
        state_n = ST_POWERUP;
        cnt_n   = '0;
        if (state == ST_POWERUP) begin
            state_n = cnt == POWERUP_LAST ? ST_RUN : ST_POWERUP;
            cnt_n   = cnt == POWERUP_LAST ? '0 : cnt + 1'b1;
        end else if (state == ST_RUN) begin
            state_n = trig ? ST_PROG : ST_RUN;
            cnt_n   = trig ? '0 : cnt;
        end else if (state == ST_PROG) begin
            cnt_n   = trig || act ? '0 : cnt_inc;
            state_n = cnt_n[C_prog_release_timeout] ? ST_RUN : ST_PROG;
        end
    end

    assign prog_n   = state_n == ST_PROG;
    assign en_n     = state_n != ST_POWERUP && !btn_s && ei[1];
    assign boot_o_n = prog_n ? (C_follow_io0 & {C_pins{ei[0]}}) | (~C_follow_io0 & C_prog_value) : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= ST_POWERUP;
            cnt         <= '0;
            pair_q      <= PAIR_IDLE;
            en_t        <= 1'b0;
            boot_t      <= '1;
            boot_o      <= '0;
            prog_active <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pair_q      <= pair;
            en_t        <= en_n;
            boot_t      <= {C_pins{!prog_n}};
            boot_o      <= boot_o_n;
            prog_active <= prog_n;
        end

endmodule

// File: tb/tb_esp32_prog_ctrl.sv
// tb_esp32_prog_ctrl: directed stimulus pushes expected output changes into a scoreboard;
// a negedge monitor pops and checks the cycle and value of every output change.
module tb_esp32_prog_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, ndtr = 1'b1, nrts = 1'b1, btn_disable = 1'b0, uart_act = 1'b0;
    logic       en_t, prog_active;
    logic [5:0] boot_t, boot_o;
    int         cyc = 0, errors = 0, checks = 0;
    int         k, t0, t1, t2, t3;

    typedef struct { int cyc; logic [13:0] val; } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [13:0] cur;
    logic [13:0] prev = {1'b0, 6'h3f, 6'h00, 1'b0};

    esp32_prog_ctrl #(
        .C_pins(6), .C_follow_io0(6'b000011), .C_prog_value(6'b001100),
        .C_filter_cycles(4), .C_powerup_en_time(3), .C_prog_release_timeout(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ndtr(ndtr), .nrts(nrts), .btn_disable(btn_disable),
        .uart_act(uart_act), .en_t(en_t), .boot_t(boot_t), .boot_o(boot_o), .prog_active(prog_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic en, input logic [5:0] bt, input logic [5:0] bo, input logic pa);
        sb.push_back('{c, {en, bt, bo, pa}});
    endtask

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cur = {en_t, boot_t, boot_o, prog_active};
            if (cur !== prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, cur, prev);
                end else begin
                    e = sb.pop_front();
                    checks += 2;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL change_cycle got=%0d exp=%0d", cyc, e.cyc);
                    end
                    if (cur !== e.val) begin
                        errors++;
                        $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, cur, e.val);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {en_t, boot_t, boot_o, prog_active}, {1'b0, 6'h3f, 6'h00, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = cyc;
        push(k + 8, 1'b1, 6'h3f, 6'h00, 1'b0);

        // trigger, then 01 while programming, then timeout
        at_cyc(k + 20);
        k = cyc;
        {ndtr, nrts} = 2'b10;
        t0 = k + 7;
        push(t0, 1'b0, 6'h00, 6'b001111, 1'b1);
        at_cyc(k + 15);
        {ndtr, nrts} = 2'b01;
        push(cyc + 7, 1'b1, 6'h00, 6'b001100, 1'b1);
        push(t0 + 64, 1'b1, 6'h3f, 6'h00, 1'b0);

        // re-trigger 40 cycles into PROG restarts the timeout
        at_cyc(t0 + 70);
        k = cyc;
        {ndtr, nrts} = 2'b10;
        t1 = k + 7;
        push(t1, 1'b0, 6'h00, 6'b001111, 1'b1);
        at_cyc(k + 10);
        {ndtr, nrts} = 2'b11;
        push(cyc + 7, 1'b1, 6'h00, 6'b001111, 1'b1);
        at_cyc(t1 + 33);
        {ndtr, nrts} = 2'b10;
        t2 = t1 + 40;
        push(t2, 1'b0, 6'h00, 6'b001111, 1'b1);
        at_cyc(t2 + 3);
        {ndtr, nrts} = 2'b11;
        push(cyc + 7, 1'b1, 6'h00, 6'b001111, 1'b1);
        push(t2 + 64, 1'b1, 6'h3f, 6'h00, 1'b0);

        // trigger lands on the timeout edge: stays in PROG
        at_cyc(t2 + 70);
        k = cyc;
        {ndtr, nrts} = 2'b10;
        t1 = k + 7;
        push(t1, 1'b0, 6'h00, 6'b001111, 1'b1);
        at_cyc(k + 10);
        {ndtr, nrts} = 2'b11;
        push(cyc + 7, 1'b1, 6'h00, 6'b001111, 1'b1);
        at_cyc(t1 + 57);
        {ndtr, nrts} = 2'b10;
        t3 = t1 + 64;
        push(t3, 1'b0, 6'h00, 6'b001111, 1'b1);
        push(t3 + 64, 1'b0, 6'h3f, 6'h00, 1'b0);

        // short pulses and a bounce on ndtr are rejected
        at_cyc(t3 + 70);
        k = cyc;
        ndtr = 1'b0;
        at_cyc(k + 3);  ndtr = 1'b1;
        at_cyc(k + 10); ndtr = 1'b0;
        at_cyc(k + 13); ndtr = 1'b1;
        at_cyc(k + 14); ndtr = 1'b0;
        at_cyc(k + 17); ndtr = 1'b1;

        // a 4-cycle pulse is exactly long enough; returning to 10 triggers
        at_cyc(k + 30);
        k = cyc;
        ndtr = 1'b0;
        push(k + 7, 1'b1, 6'h3f, 6'h00, 1'b0);
        at_cyc(k + 4);
        ndtr = 1'b1;
        t0 = k + 11;
        push(t0, 1'b0, 6'h00, 6'b001111, 1'b1);

        // btn_disable in PROG
        at_cyc(t0 + 3);
        nrts = 1'b1;
        push(cyc + 7, 1'b1, 6'h00, 6'b001111, 1'b1);
        at_cyc(t0 + 15);
        btn_disable = 1'b1;
        push(cyc + 3, 1'b0, 6'h00, 6'b001111, 1'b1);
        at_cyc(t0 + 25);
        btn_disable = 1'b0;
        push(cyc + 3, 1'b1, 6'h00, 6'b001111, 1'b1);
        push(t0 + 64, 1'b1, 6'h3f, 6'h00, 1'b0);

        // UART activity during PROG
        at_cyc(t0 + 70);
        k = cyc;
        nrts = 1'b0;
        t1 = k + 7;
        push(t1, 1'b0, 6'h00, 6'b001111, 1'b1);
`ifdef ESP32_PROG_ACTIVITY_EN
        push(t1 + 200 + 67, 1'b0, 6'h3f, 6'h00, 1'b0);
`else
        push(t1 + 64, 1'b0, 6'h3f, 6'h00, 1'b0);
`endif
        for (int i = 1; i <= 10; i++) begin
            at_cyc(t1 + 20 * i);
            uart_act = ~uart_act;
        end

        // reset mid-PROG releases the pins without a clock edge
        at_cyc(t1 + 280);
        k = cyc;
        {ndtr, nrts} = 2'b11;
        push(k + 7, 1'b1, 6'h3f, 6'h00, 1'b0);
        at_cyc(k + 10);
        {ndtr, nrts} = 2'b10;
        push(cyc + 7, 1'b0, 6'h00, 6'b001111, 1'b1);
        at_cyc(k + 25);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL queue_drained pending=%0d exp=0", sb.size());
        end
        rst_n = 1'b0;
        #2;
        check("async_reset_prog", {en_t, boot_t, boot_o, prog_active}, {1'b0, 6'h3f, 6'h00, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
